hilo_acc_unit: RTL
==================

// Module: hilo_acc_unit
// PURPOSE
//  Parametrised HI/LO special-register unit for the MEM/WB side of the core.
//  Holds the 2*DATA_W HI:LO pair, supports full and half writes (MTHI/MTLO),
//  and performs a 2-cycle atomic accumulate (MADD/MSUB style) of an externally
//  supplied 2*DATA_W addend. Uses a ready/valid op port, flush and optional read bypass.
// PARAMETERS
//  DATA_W  32  width of HI and of LO; the accumulator is 2*DATA_W wide
//  BYPASS  1   1: read ports forward same-cycle accepted write data; 0: registers only
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         asynchronous, active-high reset
//  op_valid       in   1         op request this cycle
//  op_ready       out  1         unit can accept an op this cycle
//  op_mode        in   3         0 NOP,1 WR_BOTH,2 WR_HI,3 WR_LO,4 ACC_ADD,5 ACC_SUB,6-7 NOP
//  hi_write_data  in   DATA_W    HI write value / upper half of accumulate addend
//  lo_write_data  in   DATA_W    LO write value / lower half of accumulate addend
//  flush          in   1         cancel in-flight accumulate, block acceptance
//  hi_read_data   out  DATA_W    current HI (bypassed when BYPASS=1)
//  lo_read_data   out  DATA_W    current LO (bypassed when BYPASS=1)
//  busy           out  1         accumulate in flight
//  acc_done       out  1         1-cycle pulse after an accumulate commits
//  acc_carry      out  1         carry-out (ADD) / borrow (SUB) of last committed accumulate
// BEHAVIOUR
//  Reset (async, any state): hi=0, lo=0, state=IDLE, acc_done=0, acc_carry=0,
//   addend/temp regs=0; outputs take reset values immediately, no clock needed.
//  Accept = op_valid & op_ready. op_ready = (state==IDLE) & ~flush (combinational).
//  States: IDLE -> ACC_LO -> ACC_HI -> IDLE.
//   IDLE: accepted WR_BOTH writes hi,lo; WR_HI writes hi only; WR_LO writes lo only;
//    visible on registered outputs after that edge (1-cycle latency). NOP/6/7: no effect.
//    Accepted ACC_ADD/ACC_SUB: latch addend {hi_write_data,lo_write_data} and
//    sign, go ACC_LO. hi/lo unchanged.
//   ACC_LO: temp_lo = lo +/- addend_lo (DATA_W bits), latch carry/borrow; go ACC_HI.
//   ACC_HI: hi <= hi +/- addend_hi +/- carry; lo <= temp_lo; both on same edge
//    (atomic commit); acc_carry <= final carry-out/borrow; acc_done <= 1; go IDLE.
//  Accumulate latency: accepted on edge N, HI:LO updated on edge N+2; op_ready=0
//   and busy=1 for the two cycles between (busy = state!=IDLE).
//  acc_done high exactly one cycle after commit edge; otherwise 0.
//  acc_carry holds until next committed accumulate; writes do not change it.
//  Arithmetic modulo 2^(2*DATA_W); wrap-around silent apart from acc_carry.
//  flush: in ACC_LO/ACC_HI -> next state IDLE, no hi/lo/acc_carry change, no acc_done.
//   In IDLE: op_ready=0, so nothing accepted that cycle. Flush on commit cycle wins.
//  Reads during accumulate return pre-accumulate HI:LO (no partial results).
//  BYPASS=1: on accept of WR_BOTH/WR_HI/WR_LO, written half(s) driven on read
//   ports same cycle; unwritten half and all other cycles show registers.
//   ACC results are never bypassed. BYPASS=0: read ports are the registers.
//  op_valid while op_ready=0: ignored, not queued; requester must hold/retry.
// TESTING
//  1 Assert rst mid-cycle, no clk -> hi/lo=0, busy=0, acc_done=0, acc_carry=0, op_ready=1.
//  2 WR_BOTH hi=0x12345678 lo=0x9ABCDEF0, then WR_HI 0xAAAAAAAA -> HI:LO=
//    0xAAAAAAAA_9ABCDEF0; BYPASS=1 shows 0xAAAAAAAA on hi_read_data in accept cycle.
//  3 HI:LO=0x00000000_FFFFFFFF, ACC_ADD addend 0x0_1 -> op_ready=0 two cycles,
//    reads old value until N+2, then 0x00000001_00000000, acc_done 1 cycle, acc_carry=0.
//  4 HI:LO=0, ACC_SUB addend 0x0_1 -> 0xFFFFFFFF_FFFFFFFF, acc_carry=1;
//    ACC_ADD 0x0_1 on that -> 0x0_0, acc_carry=1.
//  5 Start ACC_ADD, flush in ACC_HI -> HI:LO, acc_carry unchanged, no acc_done,
//    op_ready=1 next cycle; op_valid with flush=1 in IDLE -> no write.
//  6 rst asserted in ACC_LO -> immediate zeros, IDLE; first op after release accepted normally.

Source files
------------

// File: rtl/hilo_acc_unit.sv
// rtl/hilo_acc_unit.sv - HI/LO special-register pair with half writes and 2-cycle atomic accumulate
module hilo_acc_unit #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_mode,
  input  logic [DATA_W-1:0] hi_write_data,
  input  logic [DATA_W-1:0] lo_write_data,
  input  logic              flush,
  output logic [DATA_W-1:0] hi_read_data,
  output logic [DATA_W-1:0] lo_read_data,
  output logic              busy,
  output logic              acc_done,
  output logic              acc_carry
);

  localparam logic [2:0] MODE_WR_BOTH = 3'd1;
  localparam logic [2:0] MODE_WR_HI   = 3'd2;
  localparam logic [2:0] MODE_WR_LO   = 3'd3;
  localparam logic [2:0] MODE_ACC_ADD = 3'd4;
  localparam logic [2:0] MODE_ACC_SUB = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC_LO = 2'd1,
    S_ACC_HI = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] addend_hi_q, addend_lo_q;
  logic [DATA_W-1:0] temp_lo_q;
  logic              sub_q;
  logic              carry_lo_q;
  logic              acc_done_q;
  logic              acc_carry_q;

  logic accept;
  logic wr_hi, wr_lo, acc_start;
  logic commit;
  logic [DATA_W:0] lo_sum, hi_sum;

  assign op_ready = (state_q == S_IDLE) & ~flush;
  assign accept   = op_valid & op_ready;
  assign busy     = (state_q != S_IDLE);

  assign wr_hi     = accept & ((op_mode == MODE_WR_BOTH) | (op_mode == MODE_WR_HI));
  assign wr_lo     = accept & ((op_mode == MODE_WR_BOTH) | (op_mode == MODE_WR_LO));
  assign acc_start = accept & ((op_mode == MODE_ACC_ADD) | (op_mode == MODE_ACC_SUB));

  // A flush on the commit cycle cancels the commit entirely.
  assign commit = (state_q == S_ACC_HI) & ~flush;

  // One extra bit on each half captures carry-out or borrow (top bit set on underflow).
  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    if (sub_q) begin
      lo_sum = {1'b0, lo_q} - {1'b0, addend_lo_q};
      hi_sum = {1'b0, hi_q} - {1'b0, addend_hi_q} - {{DATA_W{1'b0}}, carry_lo_q};
    end else begin
      lo_sum = {1'b0, lo_q} + {1'b0, addend_lo_q};
      hi_sum = {1'b0, hi_q} + {1'b0, addend_hi_q} + {{DATA_W{1'b0}}, carry_lo_q};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (acc_start) state_d = S_ACC_LO;
      S_ACC_LO: state_d = flush ? S_IDLE : S_ACC_HI;
      S_ACC_HI: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      addend_hi_q <= '0;
      addend_lo_q <= '0;
      temp_lo_q   <= '0;
      sub_q       <= 1'b0;
      carry_lo_q  <= 1'b0;
      acc_done_q  <= 1'b0;
      acc_carry_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_done_q <= commit;
      if (wr_hi) hi_q <= hi_write_data;
      if (wr_lo) lo_q <= lo_write_data;
      if (acc_start) begin
        addend_hi_q <= hi_write_data;
        addend_lo_q <= lo_write_data;
        sub_q       <= (op_mode == MODE_ACC_SUB);
      end
      if ((state_q == S_ACC_LO) && !flush) begin
        temp_lo_q  <= lo_sum[DATA_W-1:0];
        carry_lo_q <= lo_sum[DATA_W];
      end
      // Both halves land on the same edge so readers never see a partial result.
      if (commit) begin
        hi_q        <= hi_sum[DATA_W-1:0];
        lo_q        <= temp_lo_q;
        acc_carry_q <= hi_sum[DATA_W];
      end
    end
  end

  assign hi_read_data = (BYPASS && wr_hi) ? hi_write_data : hi_q;
  assign lo_read_data = (BYPASS && wr_lo) ? lo_write_data : lo_q;
  assign acc_done     = acc_done_q;
  assign acc_carry    = acc_carry_q;

endmodule
